// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and default sizing shared by the round-robin arbiter files
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  localparam int ARB_N_DEF = 8;
  localparam int ARB_MAX_HOLD_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotated priority encoder; the first set req bit at or after ptr (wrapping) wins
module rr_pick import arb_pkg::*; #(
  parameter int N = ARB_N_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     oh,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    oh = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k >= N ? int'(ptr) + k - N : int'(ptr) + k;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IDX_W'(j);
        oh[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: round-robin arbiter with registered one-hot grant, binary index and hold timeout
module rr_arbiter_ctrl import arb_pkg::*; #(
  parameter int N = ARB_N_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_e state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx, pick_idx, idx_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [N-1:0] pick_oh, gnt_nx;
  logic pick_any, held, take, rel, valid_nx, timeout_nx;
  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req(req),
    .ptr(ptr),
    .oh(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign held = req[gnt_idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr <= '0;
      hcnt <= '0;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      hcnt <= hcnt_nx;
      gnt <= gnt_nx;
      gnt_idx <= idx_nx;
      gnt_valid <= valid_nx;
      timeout <= timeout_nx;
    end
  end
  // a dropped request wins over the hold limit, so a coincident release never pulses timeout
  always_comb begin
    take = state == ARB_IDLE && pick_any;
    rel = state == ARB_GRANT && (!held || hcnt == HW'(MAX_HOLD));
    state_nx = take ? ARB_GRANT : rel ? ARB_IDLE : state;
    ptr_nx = rel ? (gnt_idx == IDX_W'(N - 1) ? '0 : gnt_idx + IDX_W'(1)) : ptr;
    hcnt_nx = take ? HW'(1) : rel ? '0 : state == ARB_GRANT ? hcnt + HW'(1) : hcnt;
    gnt_nx = take ? pick_oh : rel ? '0 : gnt;
    idx_nx = take ? pick_idx : rel ? '0 : gnt_idx;
    valid_nx = take | (gnt_valid & ~rel);
    timeout_nx = rel & held;
  end
endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// tb_rr_arbiter_ctrl: scoreboard bench running two arbiters (hold limits 16 and 4) on one request stream
module tb_rr_arbiter_ctrl;
  localparam int N = 8;
  typedef struct {int ptr; int own; int held; bit to;} mdl_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] g16, g4;
  logic [2:0] i16, i4;
  logic v16, v4, t16, t4;
  mdl_t m16, m4;
  logic [12:0] q16[$], q4[$];
  int total = 0, bad = 0;
  logic [N-1:0] pat;
  always #5 clk = ~clk;
  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(g16), .gnt_idx(i16), .gnt_valid(v16), .timeout(t16)
  );
  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(g4), .gnt_idx(i4), .gnt_valid(v4), .timeout(t4)
  );
  // one cycle of the arbitration rules: ptr/owner/held-cycle count as plain integers
  function automatic mdl_t step(mdl_t s, logic [N-1:0] r, int mh);
    mdl_t n = s;
    n.to = 1'b0;
    if (s.own < 0) begin
      for (int k = 0; k < N; k++)
        if (n.own < 0 && r[(s.ptr + k) % N]) n.own = (s.ptr + k) % N;
      if (n.own >= 0) n.held = 1;
    end else if (!r[s.own] || s.held == mh) begin
      n.to = r[s.own];
      n.ptr = (s.own + 1) % N;
      n.own = -1;
      n.held = 0;
    end else n.held++;
    return n;
  endfunction
  function automatic logic [12:0] obs(mdl_t s);
    logic [N-1:0] oh = '0;
    if (s.own < 0) return {8'h00, 3'd0, 1'b0, s.to};
    oh[s.own] = 1'b1;
    return {oh, 3'(s.own), 1'b1, s.to};
  endfunction
  function automatic logic [N-1:0] gmask(mdl_t s);
    logic [N-1:0] m = '0;
    if (s.own >= 0) m[s.own] = 1'b1;
    return m;
  endfunction
  task automatic chk(string nm, logic [12:0] got, logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got gnt/idx/valid/to=%h expected=%h", nm, $time, got, exp);
    end
  endtask
  task automatic mreset();
    m16 = '{0, -1, 0, 1'b0};
    m4 = '{0, -1, 0, 1'b0};
    q16.delete();
    q4.delete();
  endtask
  task automatic drive(logic [N-1:0] r);
    req = r;
    m16 = step(m16, r, 16);
    m4 = step(m4, r, 4);
    q16.push_back(obs(m16));
    q4.push_back(obs(m4));
    @(negedge clk);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q16.size() > 0) chk("dut16", {g16, i16, v16, t16}, q16.pop_front());
      if (rst_n && q4.size() > 0) chk("dut4", {g4, i4, v4, t4}, q4.pop_front());
    end
  end
  initial begin
    mreset();
    repeat (2) @(negedge clk);
    chk("reset16", {g16, i16, v16, t16}, 13'h0);
    chk("reset4", {g4, i4, v4, t4}, 13'h0);
    rst_n = 1'b1;
    repeat (2 * N + 4) drive(8'hFF & ~gmask(m16));
    for (int c = 0; c < 10 && m16.own < 0; c++) drive(8'hFF);
    rst_n = 1'b0;
    #1;
    chk("midreset16", {g16, i16, v16, t16}, 13'h0);
    chk("midreset4", {g4, i4, v4, t4}, 13'h0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(8'h10);
    repeat (2) drive(8'h00);
    for (int c = 0; c < 20 && m16.own != 2; c++) drive(8'h04);
    drive(8'h00);
    repeat (6) drive(8'h05 & ~gmask(m16));
    drive(8'h00);
    for (int c = 0; c < 20 && m16.own != 5; c++) drive(8'h20);
    for (int c = 0; c < 8; c++) drive(8'h20 | (c[0] ? 8'h42 : 8'h00));
    repeat (3) drive(8'h00);
    for (int c = 0; c < 12; c++) begin
      pat = (m4.own == 0 && m4.held == 4) ? 8'h00 : 8'h01;
      drive(pat);
      if (pat == 8'h00) break;
    end
    repeat (3) drive(8'h00);
    repeat (40) drive(8'h01);
    repeat (3) drive(8'h00);
    pat = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) pat = 8'($urandom);
      drive($urandom_range(0, 5) == 0 ? pat & ~gmask(m16) : pat);
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_ctrl.md
# rr_arbiter_ctrl

Round-robin arbiter for up to N requesters sharing a single downstream resource. It selects the next requester with a rotating-priority search, which is a priority encode starting from a moving pointer, and registers a one-hot grant plus a binary index. The grant is held until the winner releases it or a hold timeout expires. The block sits in front of any shared datapath, such as a bus, ALU, or memory port, and provides fair, starvation-free access.

## Interface
- N, default 8: number of requesters, 2..16.
- MAX_HOLD, default 16: maximum consecutive cycles a grant is held, at least 1.
- IDX_W, default $clog2(N): width of the index output.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  N  request vector; bit i is requester i.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IDX_W  binary index of the granted requester, registered.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released.

## Operation
- State machine with two states, IDLE and GRANT.
- Rotating pointer ptr, IDX_W bits wide.
  - Search order: ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - The first set req bit in that order wins.
- IDLE:
  - If req is nonzero, latch the winner into gnt and gnt_idx, set gnt_valid, and go to GRANT.
  - Otherwise stay in IDLE with all outputs at 0.
- GRANT:
  - Hold counter hcnt, width $clog2(MAX_HOLD+1), increments every cycle. It is loaded to 1 on entry.
  - Release condition A: req[gnt_idx] is 0.
  - Release condition B: hcnt equals MAX_HOLD while req[gnt_idx] is still 1. This also pulses timeout.
  - On release, in the same cycle:
    - ptr becomes gnt_idx+1, wrapping N-1 to 0.
    - gnt and gnt_idx clear, and gnt_valid drops.
    - State goes to IDLE.
- Every handover passes through IDLE, so there is always exactly one dead cycle with no grant between consecutive grants.
- Requests arriving or dropping on non-granted lines during GRANT have no effect.
- A requester that is force-released may re-request. It is considered again only after ptr passes it.
- req is assumed synchronous to clk. The block does no synchronization.

## Timing
- Reset, asynchronous assert:
  - state is IDLE, ptr is 0, hcnt is 0.
  - gnt, gnt_idx, gnt_valid and timeout are all 0.
- Reset mid-grant drops the grant immediately, with no timeout pulse.
- Grant latency: req seen in IDLE at edge k gives gnt visible after edge k, in cycle k+1.
- Release latency: req[gnt_idx] low sampled at edge k gives gnt and gnt_valid at 0 after edge k.
- Timeout:
  - The grant covers exactly MAX_HOLD cycles.
  - timeout is high during the first IDLE cycle after release.
- Simultaneous events: if release condition A and the timeout condition B coincide, A takes precedence and there is no timeout pulse.
- With req all ones and each grant lasting one cycle, grants follow index order 0,1,…,N-1,0. Each grant is followed by one idle cycle.

## Structure
- Package arb_pkg holds:
  - the state enum arb_state_e, with values ARB_IDLE and ARB_GRANT;
  - the default constants ARB_N_DEF=8 and ARB_MAX_HOLD_DEF=16.
- Sub-module rr_pick is combinational.
  - Inputs: req and ptr.
  - Outputs: the winner's one-hot vector, its index, and an any flag.
  - Implementation: a rotated priority encoder, where the lowest index at or after ptr wins.
  - It is instantiated once in rr_arbiter_ctrl.
- All registers live in rr_arbiter_ctrl: state, ptr, hcnt, and the output registers.

## Test plan
- Reset: assert rst_n=0 mid-grant with req=8'hFF.
  - gnt=0 and gnt_valid=0 immediately.
  - After release, req=8'h10 gives gnt=8'h10 and gnt_idx=4 one cycle later.
- Rotation: req=8'hFF held; each grant released after 1 cycle by pulsing that requester's req low.
  - gnt_idx sequence is 0,1,2,…,7,0, with gnt_valid=0 for one cycle between grants.
- Pointer skip: with ptr=3 after granting idx 2, req=8'b0000_0101.
  - Grant goes to idx 0, via the wrap from 3 to 0.
  - The next grant with the same req goes to idx 2.
- Timeout: req=8'h01 held with MAX_HOLD=16.
  - gnt=8'h01 for exactly 16 cycles, then timeout=1 for one cycle.
  - Re-grant to idx 0 one cycle after that.
- Coincident release: with MAX_HOLD=4, drop req[gnt_idx] in the 4th grant cycle.
  - No timeout pulse.
  - ptr advances normally.
- Non-granted noise: while idx 5 is granted, toggle req[1] and req[6] every cycle.
  - gnt stays 8'h20 until req[5] drops.
